// File: rtl/morse_pkg.sv
// Shared constants for the Morse message scheduler: FSM encodings and
// ASCII-to-Morse ROM entry layout.
package morse_pkg;

  // Scheduler states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // Longest character the encoder can shift out
  localparam logic [3:0] MORSE_MAXLEN = 4'd8;

  // ROM entry layout: code[11:4], len[3:0]
  localparam int CODE_MSB = 11;
  localparam int CODE_LSB = 4;
  localparam int LEN_MSB  = 3;

  // An entry longer than the encoder shift register is unusable
  function automatic logic len_bad(input logic [3:0] len);
    return len > MORSE_MAXLEN;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Character FIFO between the host and the scheduler. Width 8, DEPTH entries
// (power of 2), pointers wrap naturally on their AW-bit width.
module morse_char_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; reset empties the FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; the count guards validity
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/morse_msg_sched.sv
// Morse message scheduler: buffers host characters, looks each one up in a
// synchronous ASCII-to-Morse ROM and hands it to the LED encoder with a
// one-cycle char_vald, then waits for the encoder's char_next rising edge.
module morse_msg_sched
  import morse_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023,
  parameter int CNTW    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_char,
  output logic                    in_ready,
  output logic [7:0]              rom_addr,
  input  logic [11:0]             rom_data,
  output logic                    char_vald,
  output logic [7:0]              charcode_data,
  output logic [3:0]              charlen_data,
  input  logic                    char_next,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_timeout,
  output logic                    err_len,
  output logic [CNTW-1:0]         chars_sent
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Counter value at which the wait is abandoned on the next edge
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      code_q, code_d;
  logic [3:0]      len_q, len_d;
  logic            err_len_q, err_len_d;
  logic            err_to_q, err_to_d;
  logic [CNTW-1:0] sent_q, sent_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            char_next_q, rise_q;
  logic            fifo_full, fifo_empty, pop;

  assign pop = (state_q == S_LOAD);

  morse_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (in_valid),
    .pop_i   (pop),
    .din_i   (in_char),
    .dout_o  (rom_addr),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready      = !fifo_full;
  assign char_vald     = (state_q == S_SEND);
  assign busy          = (state_q != S_IDLE) || !fifo_empty;
  assign charcode_data = code_q;
  assign charlen_data  = len_q;
  assign err_timeout   = err_to_q;
  assign err_len       = err_len_q;
  assign chars_sent    = sent_q;

  // Next-state and datapath decode for the Moore sequencer
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    len_d     = len_q;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    sent_d    = sent_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // A bad entry is dropped; the encoder keeps seeing the last character
        if (len_bad(rom_data[LEN_MSB:0])) begin
          err_len_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          code_d  = rom_data[CODE_MSB:CODE_LSB];
          len_d   = rom_data[LEN_MSB:0];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over a timeout landing on the same cycle
        if (rise_q) begin
          sent_d  = sent_q + CNTW'(1);
          state_d = fifo_empty ? S_IDLE : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      len_q     <= '0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      sent_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      len_q     <= len_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      sent_q    <= sent_d;
      tmo_q     <= tmo_d;
    end
  end

  // char_next edge detect, only armed while waiting so a level that was
  // already high when WAIT is entered never counts as completion
  always_ff @(posedge clock) begin
    if (reset) begin
      char_next_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      char_next_q <= char_next;
      rise_q      <= char_next && !char_next_q && (state_q == S_WAIT);
    end
  end

endmodule

// File: tb/tb_morse_msg_sched.sv
// Bench for morse_msg_sched: directed vectors, expected code/len pushed into
// a scoreboard queue at push time and popped by a monitor on each char_vald.
module tb_morse_msg_sched;

  localparam int DEPTH = 16;
  localparam int TO    = 30;
  localparam int CNTW  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [7:0]      in_char;
  logic            in_ready;
  logic [7:0]      rom_addr;
  logic [11:0]     rom_data;
  logic            char_vald;
  logic [7:0]      charcode_data;
  logic [3:0]      charlen_data;
  logic            char_next;
  logic            busy;
  logic [CW-1:0]   fifo_count;
  logic            err_timeout;
  logic            err_len;
  logic [CNTW-1:0] chars_sent;

  logic enc_next = 1'b0;
  logic man_next = 1'b0;
  assign char_next = enc_next | man_next;

  always #5 clock = ~clock;

  morse_msg_sched #(.DEPTH(DEPTH), .TIMEOUT(TO), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .char_vald(char_vald), .charcode_data(charcode_data),
    .charlen_data(charlen_data), .char_next(char_next), .busy(busy),
    .fifo_count(fifo_count), .err_timeout(err_timeout), .err_len(err_len),
    .chars_sent(chars_sent)
  );

  // ASCII-to-Morse ROM, one cycle read latency
  function automatic logic [11:0] rom_f(input logic [7:0] a);
    case (a)
      "M":     rom_f = {8'b11000000, 4'd2};
      "1":     rom_f = {8'b01111000, 4'd5};
      "6":     rom_f = {8'b10000000, 4'd5};
      " ":     rom_f = 12'h000;
      "T":     rom_f = {8'b10000000, 4'd1};
      "A":     rom_f = {8'b01000000, 4'd2};
      "F":     rom_f = {8'b00100000, 4'd4};
      "I":     rom_f = {8'b00000000, 4'd2};
      "#":     rom_f = {8'b10101010, 4'd9};
      default: rom_f = {8'b00000000, 4'd1};
    endcase
  endfunction

  always @(posedge clock) rom_data <= rom_f(rom_addr);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  logic [11:0] exp_q[$];
  int vald_cnt = 0, last_vald_cyc = 0, last_m = 0;
  int err_len_cnt = 0, err_to_cnt = 0, err_to_cyc = 0;
  int enc_en = 0, enc_dly = 20;
  logic gap_chk = 1'b0;
  int push_cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] ec,
                      input logic [3:0] el, input bit expect_out);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && t < 300) begin
      tick(1);
      t++;
    end
    if (t >= 300) chk("push_accept", 0, 1);
    if (expect_out) exp_q.push_back({ec, el});
    tick(1);
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_vald(input int n);
    int t;
    t = 0;
    while (vald_cnt < n && t < 500) begin
      tick(1);
      t++;
    end
    chk("wait_vald", int'(vald_cnt >= n), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      tick(1);
      t++;
    end
    chk("idle", int'(busy), 0);
  endtask

  string       s = "M16 TA FATIMA";
  logic [7:0]  ec [13] = '{8'hC0, 8'h78, 8'h80, 8'h00, 8'h80, 8'h40, 8'h00,
                           8'h20, 8'h40, 8'h80, 8'h00, 8'hC0, 8'h40};
  logic [3:0]  el [13] = '{4'd2, 4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd0,
                           4'd4, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2};

  initial begin
    int v0, s0, t0, e0, k, t;
    logic [11:0] e;
    in_valid = 1'b0;
    in_char  = 8'h00;
    reset    = 1'b1;

    fork
      // Monitor: score every char_vald against the queue, log error pulses
      forever begin
        @(negedge clock);
        if (!reset) begin
          if (char_vald) begin
            vald_cnt++;
            if (gap_chk && last_m > last_vald_cyc) chk("b2b_gap", cyc - last_m, 3);
            last_vald_cyc = cyc;
            if (exp_q.size() == 0) begin
              chk("unexpected_vald", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("charcode", int'(charcode_data), int'(e[11:4]));
              chk("charlen", int'(charlen_data), int'(e[3:0]));
            end
          end
          if (err_len) err_len_cnt++;
          if (err_timeout) begin
            err_to_cnt++;
            err_to_cyc = cyc;
          end
        end
      end
      // Encoder model: answer char_next enc_dly cycles after char_vald
      forever begin
        @(negedge clock);
        if (enc_en != 0 && char_vald && !reset) begin
          repeat (enc_dly) @(posedge clock);
          #1 enc_next = 1'b1;
          last_m = cyc + 1;
          repeat (2) @(posedge clock);
          #1 enc_next = 1'b0;
        end
      end
    join_none

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_char_vald", int'(char_vald), 0);
    chk("rst_code", int'(charcode_data), 0);
    chk("rst_len", int'(charlen_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_len", int'(err_len), 0);
    chk("rst_err_to", int'(err_timeout), 0);
    chk("rst_sent", int'(chars_sent), 0);
    chk("rst_count", int'(fifo_count), 0);

    // Single character, latency, hold until char_next
    push("M", 8'hC0, 4'd2, 1);
    k = push_cyc;
    wait_vald(1);
    chk("latency", last_vald_cyc - k, 3);
    tick(5);
    chk("hold_code", int'(charcode_data), 8'hC0);
    chk("hold_len", int'(charlen_data), 2);
    chk("vald_single_pulse", vald_cnt, 1);
    chk("hold_busy", int'(busy), 1);
    chk("hold_sent", int'(chars_sent), 0);
    man_next = 1'b1;
    tick(2);
    man_next = 1'b0;
    tick(1);
    chk("single_sent", int'(chars_sent), 1);
    chk("single_idle", int'(busy), 0);

    // String with encoder answering after 20 cycles
    enc_en = 1;
    gap_chk = 1'b1;
    v0 = vald_cnt;
    for (int i = 0; i < 13; i++) push(s[i], ec[i], el[i], 1);
    wait_idle();
    gap_chk = 1'b0;
    chk("str_valds", vald_cnt - v0, 13);
    chk("str_sent", int'(chars_sent), 14);

    // Full FIFO: 1 in flight + 16 buffered, then a blocked offer
    v0 = vald_cnt;
    s0 = int'(chars_sent);
    t0 = err_to_cnt;
    for (int i = 0; i < 17; i++)
      push((i % 2) ? 8'("T") : 8'("E"), (i % 2) ? 8'h80 : 8'h00, 4'd1, 1);
    chk("full_count", int'(fifo_count), 16);
    chk("full_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    in_char  = "T";
    tick(3);
    chk("full_ignored", int'(fifo_count), 16);
    push("T", 8'h80, 4'd1, 1);
    chk("full_after_pop", vald_cnt - v0, 2);
    chk("full_count2", int'(fifo_count), 16);
    wait_idle();
    chk("full_valds", vald_cnt - v0, 18);
    chk("full_sent", int'(chars_sent) - s0, 18);
    chk("full_no_to", err_to_cnt - t0, 0);

    // Timeout: first char aborted, next char completes
    enc_en = 0;
    v0 = vald_cnt;
    s0 = int'(chars_sent);
    t0 = err_to_cnt;
    push("E", 8'h00, 4'd1, 1);
    push("T", 8'h80, 4'd1, 1);
    wait_vald(v0 + 1);
    k = last_vald_cyc;
    t = 0;
    while (err_to_cnt == t0 && t < 100) begin
      tick(1);
      t++;
    end
    chk("to_seen", err_to_cnt - t0, 1);
    chk("to_delay", err_to_cyc - k, TO + 1);
    chk("to_sent", int'(chars_sent), s0);
    wait_vald(v0 + 2);
    man_next = 1'b1;
    tick(2);
    man_next = 1'b0;
    tick(1);
    chk("to_next_sent", int'(chars_sent), s0 + 1);
    chk("to_single", err_to_cnt - t0, 1);

    // Bad ROM entry dropped, outputs keep the previous character
    enc_en = 1;
    v0 = vald_cnt;
    s0 = int'(chars_sent);
    e0 = err_len_cnt;
    push("#", 8'h00, 4'd0, 0);
    push("A", 8'h40, 4'd2, 1);
    t = 0;
    while (err_len_cnt == e0 && t < 50) begin
      tick(1);
      t++;
    end
    chk("len_err_seen", err_len_cnt - e0, 1);
    chk("len_no_vald", vald_cnt, v0);
    chk("len_keep_code", int'(charcode_data), 8'h80);
    chk("len_keep_len", int'(charlen_data), 1);
    wait_idle();
    chk("len_valds", vald_cnt - v0, 1);
    chk("len_sent", int'(chars_sent), s0 + 1);

    // Reset mid-WAIT with char_next already high
    enc_en = 0;
    man_next = 1'b1;
    v0 = vald_cnt;
    s0 = int'(chars_sent);
    push("M", 8'hC0, 4'd2, 1);
    push("T", 8'h80, 4'd1, 0);
    wait_vald(v0 + 1);
    tick(8);
    chk("stale_sent", int'(chars_sent), s0);
    chk("stale_busy", int'(busy), 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_vald", int'(char_vald), 0);
    chk("mid_rst_code", int'(charcode_data), 0);
    chk("mid_rst_len", int'(charlen_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_sent", int'(chars_sent), 0);
    man_next = 1'b0;
    tick(6);
    chk("mid_rst_no_vald", vald_cnt, v0 + 1);
    chk("mid_rst_sent2", int'(chars_sent), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
